// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/regread/execute/memory/writeback control FSM
// Ports:
//   I_clk, I_reset                      clock, synchronous active-high reset
//   I_halt                              stop at the next instruction boundary
//   I_mem_ready                         memory completes the current request
//   I_alu_write_rD/write_pc/memory_mode registered ALU results for the current instruction
//   O_decode_en/O_regread_en/O_alu_en   per-stage enables
//   O_mem_req/O_mem_fetch/O_mem_we      memory request, fetch flag, write flag
//   O_reg_we/O_pc_we/O_pc_inc           writeback commands
//   O_halted/O_fault/O_state/O_retired  status and retired-instruction count
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_W = 16
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_halt,
  input  logic               I_mem_ready,
  input  logic               I_alu_write_rD,
  input  logic               I_alu_write_pc,
  input  logic [1:0]         I_alu_memory_mode,
  output logic               O_decode_en,
  output logic               O_regread_en,
  output logic               O_alu_en,
  output logic               O_mem_req,
  output logic               O_mem_fetch,
  output logic               O_mem_we,
  output logic               O_reg_we,
  output logic               O_pc_we,
  output logic               O_pc_inc,
  output logic               O_halted,
  output logic               O_fault,
  output logic [2:0]         O_state,
  output logic [COUNT_W-1:0] O_retired
);
  typedef enum logic [2:0] {FETCH, DECODE, REGREAD, EXECUTE, MEMORY, WRITEBACK, HALT, FAULT} state_t;
  localparam int WAIT_W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  state_t state;
  logic [WAIT_W-1:0] wait_cnt;
  logic mem_rd, mem_wr, waiting, timed_out, active;
  assign mem_rd = I_alu_memory_mode == 2'b01;
  assign mem_wr = I_alu_memory_mode == 2'b10;
  // mode 2'b11 falls through as a no-op access
  assign waiting = state == FETCH || (state == MEMORY && (mem_rd || mem_wr));
  assign timed_out = MEM_TIMEOUT != 0 && !I_mem_ready && wait_cnt == WAIT_LAST;
  assign active = !I_reset;
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state <= FETCH;
      wait_cnt <= '0;
      O_retired <= '0;
    end else begin
      // every transition clears the counter, so each wait starts from zero
      wait_cnt <= (waiting && !I_mem_ready) ? wait_cnt + 1'b1 : '0;
      case (state)
        FETCH:     state <= I_mem_ready ? DECODE : timed_out ? FAULT : FETCH;
        DECODE:    state <= REGREAD;
        REGREAD:   state <= EXECUTE;
        EXECUTE:   state <= MEMORY;
        MEMORY:    state <= (!waiting || I_mem_ready) ? WRITEBACK : timed_out ? FAULT : MEMORY;
        WRITEBACK: begin
          state <= I_halt ? HALT : FETCH;
          O_retired <= O_retired + 1'b1;
        end
        HALT:      state <= I_halt ? HALT : FETCH;
        default:   state <= FAULT;
      endcase
    end
  end
  assign O_decode_en  = active && state == DECODE;
  assign O_regread_en = active && state == REGREAD;
  assign O_alu_en     = active && state == EXECUTE;
  assign O_mem_req    = active && waiting;
  assign O_mem_fetch  = active && state == FETCH;
  assign O_mem_we     = active && state == MEMORY && mem_wr;
  assign O_reg_we     = active && state == WRITEBACK && I_alu_write_rD;
  assign O_pc_we      = active && state == WRITEBACK && I_alu_write_pc;
  assign O_pc_inc     = active && state == WRITEBACK && !I_alu_write_pc;
  assign O_halted     = state == HALT;
  assign O_fault      = state == FAULT;
  assign O_state      = state;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer with a cycle-level behavioural model
module tb_cpu_sequencer;
  localparam int T = 4;
  logic clk = 0, rst = 1, halt = 0, ready = 0, wr_rd = 0, wr_pc = 0;
  logic [1:0] mode = 0;
  logic decode_en, regread_en, alu_en, mem_req, mem_fetch, mem_we, reg_we, pc_we, pc_inc, halted, fault;
  logic [2:0] state;
  logic [15:0] retired;
  int checks = 0, failures = 0;

  cpu_sequencer #(.MEM_TIMEOUT(T), .COUNT_W(16)) dut (
    .I_clk(clk), .I_reset(rst), .I_halt(halt), .I_mem_ready(ready),
    .I_alu_write_rD(wr_rd), .I_alu_write_pc(wr_pc), .I_alu_memory_mode(mode),
    .O_decode_en(decode_en), .O_regread_en(regread_en), .O_alu_en(alu_en),
    .O_mem_req(mem_req), .O_mem_fetch(mem_fetch), .O_mem_we(mem_we),
    .O_reg_we(reg_we), .O_pc_we(pc_we), .O_pc_inc(pc_inc),
    .O_halted(halted), .O_fault(fault), .O_state(state), .O_retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: stage number 0..5 per instruction, 6 halted, 7 faulted
  int m_st = 0, m_w = 0;
  logic [15:0] m_ret = 0;
  bit m_valid = 0;

  function automatic bit mem_busy(input int st, input logic [1:0] md);
    return st == 0 || (st == 4 && (md == 2'd1 || md == 2'd2));
  endfunction

  function automatic logic [13:0] expect_vec(input int st, input logic r, input logic [1:0] md,
                                             input logic rd, input logic pc);
    bit a = !r;
    bit wb = a && st == 5;
    return {a && st == 1, a && st == 2, a && st == 3, a && mem_busy(st, md), a && st == 0,
            a && st == 4 && md == 2'd2, wb && rd, wb && pc, wb && !pc,
            st == 6, st == 7, 3'(st)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0;
      m_w <= 0;
      m_ret <= 0;
      m_valid <= 1;
    end else if (mem_busy(m_st, mode)) begin
      m_w <= ready ? 0 : m_w + 1;
      m_st <= ready ? m_st + 1 : (T != 0 && m_w == T - 1) ? 7 : m_st;
    end else begin
      m_w <= 0;
      if (m_st == 5) m_ret <= m_ret + 1'b1;
      m_st <= (m_st < 5) ? m_st + 1 : (m_st == 5 || m_st == 6) ? (halt ? 6 : 0) : 7;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cycle_outputs",
          {decode_en, regread_en, alu_en, mem_req, mem_fetch, mem_we, reg_we, pc_we, pc_inc, halted, fault, state},
          expect_vec(m_st, rst, mode, wr_rd, wr_pc));
      chk("cycle_retired", retired, m_ret);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // from FETCH with zero-wait fetch, three memory wait cycles then ready
  task automatic mem_instr(input logic [1:0] md, input logic rd, input logic [2:0] exp_mem,
                           input logic [15:0] exp_ret);
    mode = md;
    wr_rd = rd;
    wr_pc = 0;
    ready = 1;
    repeat (4) step();
    chk("mem_state", state, 4);
    for (int k = 0; k < 4; k++) begin
      ready = (k == 3);
      chk("mem_req_we_fetch", {mem_req, mem_we, mem_fetch}, exp_mem);
      step();
    end
    chk("mem_wb_state", state, 5);
    chk("mem_wb_reg_we", reg_we, rd);
    step();
    chk("mem_done_state", state, 0);
    chk("mem_retired", retired, exp_ret);
  endtask

  initial begin
    int pulses;
    step();
    step();
    chk("reset_state", state, 0);
    chk("reset_retired", retired, 0);
    rst = 0;
    ready = 1;
    wr_rd = 1;
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      chk("t1_state", state, i % 6);
      pulses += int'(alu_en);
      if (i % 6 == 5) chk("t1_wb", {reg_we, pc_inc, pc_we}, 3'b110);
      step();
    end
    chk("t1_alu_pulses", pulses, 3);
    chk("t1_retired", retired, 3);
    wr_rd = 0;
    wr_pc = 1;
    repeat (5) step();
    chk("t2_state", state, 5);
    chk("t2_wb", {pc_we, pc_inc, reg_we}, 3'b100);
    step();
    chk("t2_retired", retired, 4);
    mem_instr(2'd2, 0, 3'b110, 5);
    mem_instr(2'd1, 1, 3'b100, 6);
    mode = 0;
    wr_rd = 1;
    ready = 0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_req", mem_req, 1);
      step();
    end
    chk("t4_fault_state", state, 7);
    for (int k = 0; k < 20; k++) begin
      ready = k[0];
      chk("t4_fault_hold", {fault, mem_req, state}, 5'b10111);
      chk("t4_fault_retired", retired, 6);
      step();
    end
    rst = 1;
    step();
    rst = 0;
    chk("t4_reset_exit", {fault, state}, 4'b0000);
    chk("t4_reset_retired", retired, 0);
    for (int k = 0; k < 4; k++) begin
      ready = (k == 3);
      step();
    end
    chk("t4_late_ready", {fault, state}, 4'b0001);
    ready = 1;
    step();
    step();
    chk("t5_exec", state, 3);
    halt = 1;
    repeat (3) step();
    chk("t5_halted", {halted, state}, 4'b1110);
    chk("t5_retired", retired, 1);
    step();
    chk("t5_hold", state, 6);
    halt = 0;
    step();
    chk("t5_resume", {halted, state}, 4'b0000);
    mode = 2;
    repeat (4) step();
    ready = 0;
    step();
    step();
    chk("t6_waiting", state, 4);
    rst = 1;
    #1;
    chk("t6_rst_quiet", {mem_req, mem_we, reg_we, mem_fetch}, 0);
    step();
    rst = 0;
    chk("t6_state", state, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_retired", retired, 0);
    for (int k = 0; k < 4; k++) begin
      ready = (k == 3);
      step();
    end
    chk("t6_counter_cleared", {fault, state}, 4'b0001);
    ready = 1;
    repeat (8) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
